// File: rtl/ahb2_sram_slv.sv
// ahb2_sram_slv: AHB2 slave terminating one decoded region with an
// internal 32-bit word-organised array.
// Ports: clk, rst (async, active-high); AHB address phase hsel, haddr,
// htrans, hwrite, hsize, hburst, hprot, hreadyi; data phase hwdata;
// responses hreadyo, hresp, hrdata.
// Optional macro AHB2_SRAM_SLV_RAND_WAIT_EN adds LFSR-driven extra
// wait cycles (0..3) per accepted non-error transfer.
module ahb2_sram_slv #(
  parameter int MEM_AW      = 15,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hreadyi,
  output logic        hreadyo,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_n;

  logic [4:0]        cnt, cnt_n;
  logic [4:0]        wtot;
  logic [MEM_AW-1:0] addr_q;
  logic [1:0]        off_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [3:0]        be;
  logic              open_st;
  logic              accept;
  logic              err;
  logic              we;

  logic [31:0] mem [2**MEM_AW];

  // Beats are decoded from their own address; burst type,
  // protection and the aliased upper address bits are not needed.
  logic unused;
  assign unused = ^{haddr[31:MEM_AW+2], hburst, hprot};

  // Only states that drive hreadyo high may take a new address.
  assign open_st = (state == S_IDLE) | (state == S_ACC) |
                   (state == S_ERR2);
  assign accept  = open_st & hsel & hreadyi & htrans[1];

  assign err = (hsize > 3'd2) |
               ((hsize == 3'd1) & haddr[0]) |
               ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

`ifdef AHB2_SRAM_SLV_RAND_WAIT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 8'h5A;
    end else if (accept) begin
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign wtot = 5'(WAIT_STATES) + {3'b000, lfsr[1:0]};
`else
  assign wtot = 5'(WAIT_STATES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      off_q  <= '0;
      wr_q   <= 1'b0;
      size_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        addr_q <= haddr[MEM_AW+1:2];
        off_q  <= haddr[1:0];
        wr_q   <= hwrite;
        size_q <= hsize[1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_WAIT: begin
        if (cnt == 5'd0) begin
          state_n = S_ACC;
        end else begin
          cnt_n = cnt - 5'd1;
        end
      end
      S_ERR1: state_n = S_ERR2;
      default: begin
        if (accept) begin
          if (err) begin
            state_n = S_ERR1;
          end else if (wtot != 5'd0) begin
            state_n = S_WAIT;
            cnt_n   = wtot - 5'd1;
          end else begin
            state_n = S_ACC;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  // Little-endian byte lanes from the latched offset and size.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be[off_q] = 1'b1;
      2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Errored transfers never reach ACC, so they cannot write.
  assign we = (state == S_ACC) & wr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  assign hrdata  = ((state == S_ACC) && !wr_q) ? mem[addr_q]
                                               : 32'h0;
  assign hreadyo = !((state == S_WAIT) || (state == S_ERR1));
  assign hresp   = ((state == S_ERR1) || (state == S_ERR2))
                   ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// tb_ahb2_sram_slv: directed bench for ahb2_sram_slv with two
// instances, WAIT_STATES=0 (dut0) and WAIT_STATES=3 (dut3).
module tb_ahb2_sram_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        sel;

  logic        ry0, ry3;
  logic [1:0]  rs0, rs3;
  logic [31:0] rd0, rd3;
  logic        ready;
  logic [1:0]  resp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb2_sram_slv #(.MEM_AW(15), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .hsel(hsel & ~sel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyi(ry0), .hreadyo(ry0), .hresp(rs0), .hrdata(rd0)
  );

  ahb2_sram_slv #(.MEM_AW(15), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .hsel(hsel & sel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyi(ry3), .hreadyo(ry3), .hresp(rs3), .hrdata(rd3)
  );

  assign ready = sel ? ry3 : ry0;
  assign resp  = sel ? rs3 : rs0;
  assign rdata = sel ? rd3 : rd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  // Single non-pipelined transfer; waits capped at 40.
  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rdo, output int waits,
                      output logic [1:0] rso);
    hsel = 1'b1; htrans = 2'b10; haddr = a;
    hwrite = w; hsize = sz;
    tick();
    idle_bus();
    hwdata = wd;
    waits = 0;
    while (ready !== 1'b1 && waits < 40) begin
      waits++;
      tick();
    end
    rdo = rdata;
    rso = resp;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({ry0, rs0, rd0} !== {1'b1, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset0 got %b/%h/%h exp 1/0/0", ry0, rs0, rd0);
    end
    checks++;
    if ({ry3, rs3, rd3} !== {1'b1, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset3 got %b/%h/%h exp 1/0/0", ry3, rs3, rd3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word();
    logic [31:0] d; int w; logic [1:0] r;
    sel = 1'b0;
    xfer(32'h100, 1'b1, 3'd2, 32'hDEADBEEF, d, w, r);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL wr_waits got %0d exp 0", w);
    end
    xfer(32'h100, 1'b0, 3'd2, 32'h0, d, w, r);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL rd_waits got %0d exp 0", w);
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_word got %h exp deadbeef", d);
    end
    checks++;
    if (r !== 2'b00) begin
      errors++; $display("FAIL rd_resp got %h exp 0", r);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] d; int w; logic [1:0] r;
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(32'h200 + i, 1'b1, 3'd0,
           {24'h0, b[i]} << (8 * i), d, w, r);
    end
    xfer(32'h202, 1'b1, 3'd1, 32'hAABB_0000, d, w, r);
    xfer(32'h200, 1'b0, 3'd2, 32'h0, d, w, r);
    checks++;
    if (d !== 32'hAABB2211) begin
      errors++; $display("FAIL lanes got %h exp aabb2211", d);
    end
    xfer(32'h201, 1'b0, 3'd0, 32'h0, d, w, r);
    checks++;
    if (d !== 32'hAABB2211) begin
      errors++; $display("FAIL byte_rd got %h exp aabb2211", d);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h104;
    hwrite = 1'b1; hsize = 3'd2;
    tick();
    hwdata = 32'h0BADF00D;
    haddr = 32'h104; hwrite = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL b2b_wr_rdy got %b exp 1", ready);
    end
    tick();
    idle_bus();
    checks++;
    if (rdata !== 32'h0BADF00D || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rd got %h/%b exp 0badf00d/1", rdata, ready);
    end
    tick();
  endtask

  task automatic test_waits();
    logic [31:0] d; int w; logic [1:0] r;
    int total;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer(32'h40 + 4 * i, 1'b1, 3'd2, 32'hA000_0000 + i, d, w, r);
      if (i == 0) begin
        checks++;
        if (w !== 3) begin
          errors++; $display("FAIL ws_wr got %0d exp 3", w);
        end
      end
    end
    total = 0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40;
    hwrite = 1'b0; hsize = 3'd2; hburst = 3'd3;
    tick();
    for (int bt = 0; bt < 4; bt++) begin
      if (bt < 3) begin
        htrans = 2'b11; haddr = 32'h40 + 4 * (bt + 1);
      end else begin
        idle_bus();
      end
      w = 0;
      while (ready !== 1'b1 && w < 40) begin
        w++; total++; tick();
      end
      total++;
      checks++;
      if (w !== 3) begin
        errors++; $display("FAIL beat%0d_waits got %0d exp 3", bt, w);
      end
      checks++;
      if (rdata !== 32'hA000_0000 + bt) begin
        errors++;
        $display("FAIL beat%0d_data got %h exp %h", bt, rdata,
                 32'hA000_0000 + bt);
      end
      tick();
    end
    hburst = 3'd0;
    checks++;
    if (total !== 16) begin
      errors++; $display("FAIL burst_cycles got %0d exp 16", total);
    end
  endtask

  task automatic test_error();
    logic [31:0] d; int w; logic [1:0] r;
    logic [2:0] szs [2];
    logic [31:0] ads [2];
    sel = 1'b0;
    szs[0] = 3'd2; ads[0] = 32'h102;
    szs[1] = 3'd1; ads[1] = 32'h101;
    for (int k = 0; k < 2; k++) begin
      hsel = 1'b1; htrans = 2'b10; haddr = ads[k];
      hwrite = 1'b1; hsize = szs[k];
      tick();
      idle_bus();
      hwdata = 32'hCAFEF00D;
      checks++;
      if ({ready, resp} !== {1'b0, 2'b01}) begin
        errors++;
        $display("FAIL err1_%0d got %b/%h exp 0/1", k, ready, resp);
      end
      tick();
      checks++;
      if ({ready, resp} !== {1'b1, 2'b01}) begin
        errors++;
        $display("FAIL err2_%0d got %b/%h exp 1/1", k, ready, resp);
      end
      tick();
      checks++;
      if ({ready, resp} !== {1'b1, 2'b00}) begin
        errors++;
        $display("FAIL err_end%0d got %b/%h exp 1/0", k, ready, resp);
      end
    end
    xfer(32'h100, 1'b0, 3'd2, 32'h0, d, w, r);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_nowr got %h exp deadbeef", d);
    end
  endtask

  task automatic test_idle_busy();
    logic [31:0] d; int w; logic [1:0] r;
    sel = 1'b0;
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h100;
    hwrite = 1'b1; hsize = 3'd2;
    tick();
    hwdata = 32'hBAD0BAD0;
    htrans = 2'b01;
    checks++;
    if ({ready, resp} !== {1'b1, 2'b00}) begin
      errors++;
      $display("FAIL idle_cyc got %b/%h exp 1/0", ready, resp);
    end
    tick();
    hsel = 1'b0; htrans = 2'b10;
    checks++;
    if ({ready, resp} !== {1'b1, 2'b00}) begin
      errors++;
      $display("FAIL busy_cyc got %b/%h exp 1/0", ready, resp);
    end
    tick();
    idle_bus();
    checks++;
    if ({ready, resp} !== {1'b1, 2'b00}) begin
      errors++;
      $display("FAIL nosel_cyc got %b/%h exp 1/0", ready, resp);
    end
    tick();
    xfer(32'h100, 1'b0, 3'd2, 32'h0, d, w, r);
    checks++;
    if (d !== 32'hDEADBEEF || w !== 0) begin
      errors++;
      $display("FAIL nosel_rd got %h/%0d exp deadbeef/0", d, w);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; int w; logic [1:0] r;
    sel = 1'b1;
    xfer(32'h300, 1'b1, 3'd2, 32'h12345678, d, w, r);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h300;
    hwrite = 1'b1; hsize = 3'd2;
    tick();
    idle_bus();
    hwdata = 32'h99999999;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL abort_wait got %b exp 0", ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ready, resp, rdata} !== {1'b1, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL abort_rst got %b/%h/%h exp 1/0/0",
               ready, resp, rdata);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    xfer(32'h300, 1'b0, 3'd2, 32'h0, d, w, r);
    checks++;
    if (d !== 32'h12345678) begin
      errors++; $display("FAIL abort_old got %h exp 12345678", d);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; hwdata = '0;
    test_reset();
    test_word();
    test_lanes();
    test_back_to_back();
    test_waits();
    test_error();
    test_idle_busy();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb2_sram_slv.md
Name: ahb2_sram_slv

Overview:
- Synthesizable AHB2 slave that terminates one decoded region of the shared multi-master AHB bus, for example the 128 KB windows at 0x0000_0000 and 0x0002_0000.
- Serves the compressor and decompressor DMA masters' reads and writes from an internal word-organised array.
- Supports programmable wait states, byte/halfword/word sizes with byte lanes, and a two-cycle ERROR response.
- Replaces behavioural memory models in synthesis and FPGA builds.

Parameters:
- MEM_AW, 15: word-address width; array depth = 2**MEM_AW words of 32 bits; uses haddr[MEM_AW+1:2].
- WAIT_STATES, 0: fixed wait cycles inserted per accepted NONSEQ/SEQ transfer, legal range 0..15.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select from the bus decoder.
- haddr  in  32  address; only bits [MEM_AW+1:0] are used.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = halfword, 2 = word; any other value is illegal.
- hburst  in  3  burst type; ignored, since every beat is decoded from its own address.
- hprot  in  4  ignored.
- hwdata  in  32  write data, valid in the data phase.
- hreadyi  in  1  bus-wide HREADY; qualifies address-phase sampling.
- hreadyo  out  1  slave ready.
- hresp  out  2  OKAY=0, ERROR=1.
- hrdata  out  32  read data.

Behaviour:
Reset values:
- hreadyo=1, hresp=OKAY, hrdata=0, state=IDLE, wait counter=0.
- Array contents are not reset.
- Assertion of rst mid-transfer aborts immediately; a pending write is discarded.

Address-phase accept:
- Accept occurs when hsel & hreadyi & htrans[1]=1 (NONSEQ or SEQ).
- On accept, latch addr, hwrite, hsize and err.
- err = (hsize>2) | (hsize==1 & haddr[0]) | (hsize==2 & haddr[1:0]!=0).
- hsel & hreadyi with IDLE or BUSY: no data phase; the next cycle is a zero-wait OKAY.

States:
- IDLE: hreadyo=1, OKAY.
  - accept & err -> ERR1.
  - accept & WAIT_STATES>0 -> WAIT with cnt=WAIT_STATES-1.
  - accept otherwise -> ACC.
- WAIT: hreadyo=0, OKAY, cnt decrements; cnt==0 -> ACC.
- ACC: hreadyo=1, OKAY, final data cycle.
  - Write: byte lanes committed at the closing edge.
  - Read: hrdata = array[latched addr], full word, combinational from the latched address.
  - Back-to-back accept in the same cycle follows the IDLE rules; otherwise -> IDLE.
- ERR1: hreadyo=0, hresp=ERROR; always -> ERR2.
- ERR2: hreadyo=1, hresp=ERROR; accept follows the IDLE rules; otherwise -> IDLE.
- An errored write never modifies the array.

Byte lanes (little-endian):
- Byte: lane haddr[1:0].
- Halfword: lanes {haddr[1],0} and {haddr[1],1}.
- Word: all four lanes.

Ordering:
- A write in ACC followed by a read of the same word in the next transfer returns the new data; the array is updated before that read's data phase.

Latency:
- WAIT_STATES=0: a single transfer completes in 2 cycles (address + data).
- Pipelined beats: one per cycle.

Address range:
- Addresses beyond the array alias modulo the array size; the decoder owns range checking.

Optional Feature:
Macro: AHB2_SRAM_SLV_RAND_WAIT_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 0x5A at reset) steps once per accept.
  - Each accepted non-error transfer gets WAIT_STATES + lfsr[1:0] wait cycles.
  - The error path is unchanged.
- Undefined: fixed WAIT_STATES; the LFSR is absent.

Test Plan:
1. WAIT_STATES=0: write word 0xDEADBEEF @0x100, then read @0x100 -> read data phase has hreadyo=1 in its first cycle, hrdata=0xDEADBEEF, hresp=OKAY.
2. Byte writes 0x11,0x22,0x33,0x44 to 0x200..0x203, then halfword write 0xAABB @0x202, then word read @0x200 -> 0xAABB2211.
3. WAIT_STATES=3: 4-beat INCR4 read from 0x40 -> each beat has hreadyo low for exactly 3 cycles; 16 data-phase cycles total; data matches prior writes.
4. Word write @0x102 (misaligned) -> ERR1 with hreadyo=0/ERROR, then ERR2 with hreadyo=1/ERROR; subsequent read @0x100 returns the unchanged prior value.
5. NONSEQ read interleaved with BUSY and IDLE cycles, plus hsel=0 transfers -> no array access and no wait on BUSY/IDLE; non-selected cycles are ignored.
6. Assert rst during the WAIT of a write to 0x300 -> outputs return to reset values immediately; a read of 0x300 after reset shows the old value.
